// File: rtl/arbiter_pkg.sv
// Shared sizing and clamp helpers for the multi-level priority arbiter.
package arbiter_pkg;

  function automatic int prio_width(input int levels);
    return (levels < 2) ? 1 : $clog2(levels);
  endfunction

  function automatic int cnt_width(input int thr);
    return (thr < 1) ? 1 : $clog2(thr + 1);
  endfunction

  function automatic int clamp_level(input int lvl, input int levels);
    return (lvl >= levels) ? levels - 1 : lvl;
  endfunction

endpackage

// File: rtl/rr_find_first.sv
// Rotating find-first: first set mask bit after start, wrapping modulo N.
module rr_find_first #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  int p;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    p     = 0;
    for (int k = 1; k <= N; k++) begin
      p = (int'(start) + k) % N;
      if (!found && mask[p]) begin
        found = 1'b1;
        idx   = IW'(p);
      end
    end
  end

endmodule

// File: rtl/multi_level_priority_arbiter.sv
// Priority arbiter with aging promotion, round-robin tie break
// and a single registered output slot.
module multi_level_priority_arbiter
  import arbiter_pkg::*;
#(
  parameter int NUM_REQUEST                  = 4,
  parameter int SINGLE_REQUEST_WIDTH_IN_BITS = 64,
  parameter int NUM_PRIORITY_LEVEL           = 4,
  parameter int STARVATION_THRESHOLD         = 16,
  localparam int PW = prio_width(NUM_PRIORITY_LEVEL),
  localparam int W  = SINGLE_REQUEST_WIDTH_IN_BITS
) (
  input  logic                     clk_in,
  input  logic                     reset_n_in,
  input  logic [NUM_REQUEST*W-1:0] request_flatted_in,
  input  logic [NUM_REQUEST-1:0]   request_valid_flatted_in,
  input  logic [NUM_REQUEST*PW-1:0] request_priority_flatted_in,
  output logic [NUM_REQUEST-1:0]   issue_ack_out,
  output logic [W-1:0]             request_out,
  output logic                     request_valid_out,
  input  logic                     issue_ack_in,
  output logic [NUM_REQUEST-1:0]   urgent_flatted_out
);

  localparam int CW = cnt_width(STARVATION_THRESHOLD);
  localparam int IW = $clog2(NUM_REQUEST);
  localparam int RW = $clog2(NUM_PRIORITY_LEVEL + 1);
  localparam logic [CW-1:0] THR = CW'(STARVATION_THRESHOLD);

  logic [IW-1:0]          last_q;
  logic [CW-1:0]          cnt_q [NUM_REQUEST];
  logic [NUM_REQUEST-1:0] eligible;
  logic [NUM_REQUEST-1:0] tier_mask;
  logic [RW-1:0]          rank [NUM_REQUEST];
  logic [RW-1:0]          top_rank;
  logic                   found;
  logic [IW-1:0]          win;
  logic                   load;
  logic                   grant;
  logic                   idle_load;

  assign load      = !request_valid_out || issue_ack_in;
  assign grant     = load && found;
  assign idle_load = load && !found;

  always_comb begin
    for (int i = 0; i < NUM_REQUEST; i++) begin
      urgent_flatted_out[i] = (STARVATION_THRESHOLD != 0)
                           && (cnt_q[i] == THR);
    end
  end

  // urgent requesters sit one rank above the highest real level
  always_comb begin
    eligible  = request_valid_flatted_in & ~issue_ack_out;
    top_rank  = '0;
    tier_mask = '0;
    for (int i = 0; i < NUM_REQUEST; i++) begin
      if (urgent_flatted_out[i]) begin
        rank[i] = RW'(NUM_PRIORITY_LEVEL);
      end else begin
        rank[i] = RW'(clamp_level(
          int'(request_priority_flatted_in[i*PW +: PW]),
          NUM_PRIORITY_LEVEL));
      end
      if (eligible[i] && rank[i] > top_rank) begin
        top_rank = rank[i];
      end
    end
    for (int i = 0; i < NUM_REQUEST; i++) begin
      tier_mask[i] = eligible[i] && (rank[i] == top_rank);
    end
  end

  rr_find_first #(
    .N  (NUM_REQUEST),
    .IW (IW)
  ) u_find (
    .mask  (tier_mask),
    .start (last_q),
    .found (found),
    .idx   (win)
  );

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      request_out       <= '0;
      request_valid_out <= 1'b0;
      issue_ack_out     <= '0;
      last_q            <= IW'(NUM_REQUEST - 1);
    end else begin
      issue_ack_out <= '0;
      unique case (1'b1)
        grant: begin
          request_out       <= request_flatted_in[int'(win)*W +: W];
          request_valid_out <= 1'b1;
          last_q            <= win;
          issue_ack_out     <= NUM_REQUEST'(1) << win;
        end
        idle_load: begin
          request_out       <= '0;
          request_valid_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < NUM_REQUEST; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQUEST; i++) begin
        if (!request_valid_flatted_in[i]
            || (grant && win == IW'(i))) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] != THR) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_level_priority_arbiter.sv
// Directed scoreboard bench for multi_level_priority_arbiter
// (4 requesters, 8-bit payload, 4 levels, threshold 3).
module tb_multi_level_priority_arbiter;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  pay [4];
  logic [1:0]  pr [4];
  logic [3:0]  valid;
  logic        ack_in;
  logic [31:0] req_flat;
  logic [7:0]  prio_flat;
  logic [3:0]  issue_ack_out;
  logic [7:0]  request_out;
  logic        request_valid_out;
  logic [3:0]  urgent;

  exp_t sb [$];
  exp_t mon_e;
  int   total;
  int   bad;

  assign req_flat  = {pay[3], pay[2], pay[1], pay[0]};
  assign prio_flat = {pr[3], pr[2], pr[1], pr[0]};

  multi_level_priority_arbiter #(
    .NUM_REQUEST                  (4),
    .SINGLE_REQUEST_WIDTH_IN_BITS (8),
    .NUM_PRIORITY_LEVEL           (4),
    .STARVATION_THRESHOLD         (3)
  ) dut (
    .clk_in                      (clk),
    .reset_n_in                  (rst_n),
    .request_flatted_in          (req_flat),
    .request_valid_flatted_in    (valid),
    .request_priority_flatted_in (prio_flat),
    .issue_ack_out               (issue_ack_out),
    .request_out                 (request_out),
    .request_valid_out           (request_valid_out),
    .issue_ack_in                (ack_in),
    .urgent_flatted_out          (urgent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input logic [7:0] data);
    exp_t e;
    e.idx  = idx;
    e.data = data;
    sb.push_back(e);
  endtask

  // A fresh grant is presented exactly when the ack pulse is high.
  always @(negedge clk) begin
    if (rst_n && issue_ack_out != 4'b0) begin
      chk("ack_with_valid", 64'(request_valid_out), 64'd1);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_grant ack=%b data=%0h",
                 issue_ack_out, request_out);
      end else begin
        mon_e = sb.pop_front();
        chk("grant_onehot", 64'(issue_ack_out),
            64'(4'b0001 << mon_e.idx));
        chk("grant_data", 64'(request_out), 64'(mon_e.data));
      end
    end
  end

  task automatic chk_idle(input string name);
    chk(name, 64'(request_valid_out), 64'd0);
    chk(name, 64'(request_out), 64'd0);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b1;
    valid  = 4'b0;
    ack_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pay[i] = 8'hA0 + 8'(i);
      pr[i]  = 2'd0;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(request_valid_out), 64'd0);
    chk("rst_data", 64'(request_out), 64'd0);
    chk("rst_ack", 64'(issue_ack_out), 64'd0);
    chk("rst_urgent", 64'(urgent), 64'd0);
    repeat (2) cyc();
    rst_n = 1'b1;

    // round robin over four equal requesters
    ack_in = 1'b1;
    push(0, 8'hA0);
    push(1, 8'hA1);
    push(2, 8'hA2);
    push(3, 8'hA3);
    push(0, 8'hA0);
    valid = 4'b1111;
    repeat (5) cyc();
    valid = 4'b0;
    cyc();
    chk_idle("rr_drain");
    chk("rr_urgent_clear", 64'(urgent), 64'd0);

    // higher level wins
    pr[0] = 2'd1;
    pr[1] = 2'd3;
    push(1, 8'hA1);
    valid = 4'b0011;
    cyc();
    valid = 4'b0;
    cyc();
    chk_idle("prio_drain");

    // aging promotes a low-priority requester
    pr[0] = 2'd0;
    pr[1] = 2'd3;
    push(1, 8'hA1);
    valid = 4'b0011;
    cyc();
    ack_in = 1'b0;
    cyc();
    chk("age_not_yet", 64'(urgent), 64'd0);
    cyc();
    chk("age_urgent", 64'(urgent), 64'b0001);
    chk("age_hold", 64'(request_out), 64'hA1);
    push(0, 8'hA0);
    ack_in = 1'b1;
    cyc();
    chk("age_cleared", 64'(urgent[0]), 64'd0);
    valid = 4'b0;
    cyc();
    chk("age_all_clear", 64'(urgent), 64'd0);
    chk_idle("age_drain");

    // stall: slot holds, late payload change ignored
    pr[1] = 2'd0;
    pay[2] = 8'h5C;
    push(2, 8'h5C);
    valid = 4'b0100;
    cyc();
    ack_in = 1'b0;
    pay[2] = 8'h77;
    valid = 4'b0110;
    repeat (5) begin
      cyc();
      chk("stall_data", 64'(request_out), 64'h5C);
      chk("stall_valid", 64'(request_valid_out), 64'd1);
      chk("stall_ack", 64'(issue_ack_out), 64'd0);
    end
    push(1, 8'hA1);
    ack_in = 1'b1;
    cyc();
    valid = 4'b0;
    pay[2] = 8'hA2;
    cyc();
    chk_idle("stall_drain");

    // single requester: grant every other cycle
    push(3, 8'hA3);
    push(3, 8'hA3);
    push(3, 8'hA3);
    valid = 4'b1000;
    cyc();
    cyc();
    chk("single_gap1", 64'(request_valid_out), 64'd0);
    cyc();
    cyc();
    chk("single_gap2", 64'(request_valid_out), 64'd0);
    cyc();
    valid = 4'b0;
    cyc();
    chk_idle("single_drain");

    // reset while a request is held
    push(0, 8'hA0);
    ack_in = 1'b0;
    valid = 4'b0011;
    cyc();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(request_valid_out), 64'd0);
    chk("mid_rst_data", 64'(request_out), 64'd0);
    chk("mid_rst_ack", 64'(issue_ack_out), 64'd0);
    chk("mid_rst_urgent", 64'(urgent), 64'd0);
    @(posedge clk);
    #3;
    push(0, 8'hA0);
    ack_in = 1'b1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_wait", 64'(request_valid_out), 64'd0);
    cyc();
    valid = 4'b0;
    cyc();
    chk_idle("post_rst_drain");

    repeat (2) cyc();
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_level_priority_arbiter.md
MULTI_LEVEL_PRIORITY_ARBITER -- requirements
Module: multi_level_priority_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUEST, default 4, meaning the number of requesters (minimum 2).
REQ-002 SHALL have parameter SINGLE_REQUEST_WIDTH_IN_BITS, default 64, meaning the payload width per requester.
REQ-003 SHALL have parameter NUM_PRIORITY_LEVEL, default 4, meaning the number of priority levels; level NUM_PRIORITY_LEVEL-1 is highest.
REQ-004 SHALL have parameter STARVATION_THRESHOLD, default 16, meaning the wait cycles before a requester is promoted to urgent; 0 disables aging.
REQ-005 SHALL have port clk_in, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset_n_in, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port request_flatted_in, input, NUM_REQUEST*SINGLE_REQUEST_WIDTH_IN_BITS bits: payloads, with requester i at slice [i*W +: W].
REQ-008 SHALL have port request_valid_flatted_in, input, NUM_REQUEST bits: per-requester valid.
REQ-009 SHALL have port request_priority_flatted_in, input, NUM_REQUEST*PRIORITY_WIDTH bits: per-requester level, where PRIORITY_WIDTH = max(1, clog2(NUM_PRIORITY_LEVEL)).
REQ-010 SHALL have port issue_ack_out, output, NUM_REQUEST bits: registered one-hot acceptance pulse.
REQ-011 SHALL have port request_out, output, SINGLE_REQUEST_WIDTH_IN_BITS bits: the granted payload.
REQ-012 SHALL have port request_valid_out, output, 1 bit: the output slot holds a request.
REQ-013 SHALL have port issue_ack_in, input, 1 bit: the downstream consumes request_out.
REQ-014 SHALL have port urgent_flatted_out, output, NUM_REQUEST bits: per-requester starvation-promoted status.

Function
REQ-015 The output slot SHALL load when request_valid_out=0 or (request_valid_out=1 and issue_ack_in=1) ("load cycle"); otherwise it SHALL hold request_out and request_valid_out.
REQ-016 A requester SHALL be eligible when its valid bit=1 and its issue_ack_out bit=0 in the same cycle; this prevents double-grant during the ack pulse.
REQ-017 Effective rank SHALL be: any urgent requester above all non-urgent requesters; among the non-urgent, the higher priority level wins; priority values >= NUM_PRIORITY_LEVEL SHALL be clamped to the top level.
REQ-018 Ties within the winning rank SHALL be broken round-robin, searching indices last_send_index+1, +2, … modulo NUM_REQUEST.
REQ-019 On a load cycle with a winner g, the arbiter SHALL, at the next edge, set request_out to payload g, set request_valid_out=1, set last_send_index=g, and set issue_ack_out to one-hot g for exactly one cycle.
REQ-020 On a load cycle with no eligible requester, the arbiter SHALL clear request_valid_out and request_out to 0 and leave last_send_index unchanged.
REQ-021 issue_ack_out SHALL be 0 in every cycle not immediately following a grant.
REQ-022 Latency SHALL be one cycle from request to request_valid_out; sustained throughput SHALL be one grant per cycle when issue_ack_in is held at 1 and at least two eligible requesters alternate.
REQ-023 Per-requester wait counter, clog2(STARVATION_THRESHOLD+1) bits: SHALL increment each cycle the requester is valid and not granted, saturate at STARVATION_THRESHOLD, and clear on grant or when valid=0.
REQ-024 urgent_flatted_out[i] SHALL be 1 if and only if STARVATION_THRESHOLD≠0 and counter i equals STARVATION_THRESHOLD.
REQ-025 Payload and priority inputs SHALL be sampled only on the load edge; later changes SHALL NOT alter request_out.

Reset
REQ-026 Asserting reset_n_in=0 SHALL immediately force request_out=0, request_valid_out=0, issue_ack_out=0, urgent_flatted_out=0, all counters=0, and last_send_index=NUM_REQUEST-1, so that index 0 is searched first.
REQ-027 A reset asserted mid-transfer SHALL discard the held request without an ack; the first grant after reset_n_in rises SHALL occur no earlier than the first rising edge with reset_n_in=1.

Structure
REQ-028 PRIORITY_WIDTH, the counter-width function, and the clamp rule SHALL reside in shared package arbiter_pkg.
REQ-029 The rotating find-first search (input: mask and start index; outputs: found flag and index) SHALL be sub-module rr_find_first, instantiated once per rank tier or once on the tier-selected mask.

Verification (NUM_REQUEST=4, W=8, levels=4, threshold=3)
REQ-030 Reset then valid=4'b1111, all priority 0, issue_ack_in=1 -> grant order 0,1,2,3,0; issue_ack_out 0001,0010,0100,1000 each one cycle after the matching grant.
REQ-031 valid=4'b0011, priority req0=1, req1=3, payloads 0xA0/0xA1 -> request_out=0xA1 first.
REQ-032 req1 priority 3 continuously valid, req0 priority 0 valid -> urgent_flatted_out[0]=1 after 3 waiting cycles and req0 granted at the next load cycle; its counter clears.
REQ-033 issue_ack_in=0 for 5 cycles with slot full -> request_out stable, issue_ack_out=0; after ack, the next grant appears one cycle later.
REQ-034 Single requester valid every cycle, issue_ack_in=1 -> grant every other cycle only (ack-pending mask), with request_valid_out=0 in between.
REQ-035 reset_n_in pulled low while request_valid_out=1 -> all outputs 0 asynchronously; after release, arbitration restarts at index 0.
